// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: four-master round-robin arbiter for the shared system bus.
// Grants are registered and active low; a watchdog reclaims the bus when the
// owner's strobe waits too long for slave ready.
module bus_arbiter_rr #(
    parameter int TIMEOUT_CYCLES = 256,  // stalled cycles before reclaim, >= 2
    parameter int CNT_WIDTH      = 8     // 2**CNT_WIDTH >= TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    input  logic       bus_as_,
    input  logic       bus_rdy_,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] err_master
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TIMEOUT
    } state_t;

    // Last count value before the watchdog fires.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [3:0]           req;        // active-high view of the request pins
    logic [3:0]           grnt_n;     // active-low grant register
    logic [1:0]           last;       // most recently granted master
    logic [CNT_WIDTH-1:0] count;      // stalled-strobe cycles of current owner
    logic [1:0]           winner;
    logic                 any_req;
    logic                 owner_req;
    logic                 stall;

    assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign any_req   = |req;
    assign owner_req = req[owner];
    // Strobe out and the slave has not answered yet.
    assign stall     = !bus_as_ && bus_rdy_;

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

    // Round-robin pick: first requester at last+1 .. last+4 (mod 4).
    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no latch is inferred.
        winner = last;
        // Walk from the farthest candidate down so the nearest requester is written last.
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                winner = last + 2'(i);
            end
        end
    end

    // Arbitration state machine, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            state      <= ST_IDLE;
            grnt_n     <= 4'hF;
            busy       <= 1'b0;
            owner      <= 2'd0;
            timeout    <= 1'b0;
            err_master <= 2'd0;
            last       <= 2'd3;
            count      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (any_req) begin
                        grnt_n <= ~(4'b0001 << winner);
                        owner  <= winner;
                        last   <= winner;
                        busy   <= 1'b1;
                        state  <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (!owner_req) begin
                        // Owner released: a release always beats a pending timeout.
                        count <= '0;
                        if (any_req) begin
                            grnt_n <= ~(4'b0001 << winner);
                            owner  <= winner;
                            last   <= winner;
                        end else begin
                            grnt_n <= 4'hF;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else if (stall) begin
                        if (count == CNT_LAST) begin
                            // Reclaim: the offender becomes lowest priority next round.
                            grnt_n     <= 4'hF;
                            busy       <= 1'b0;
                            timeout    <= 1'b1;
                            err_master <= owner;
                            last       <= owner;
                            count      <= '0;
                            state      <= ST_TIMEOUT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        count <= '0;
                    end
                end

                ST_TIMEOUT: begin
                    count <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    grnt_n <= 4'hF;
                    busy   <= 1'b0;
                    count  <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: table vectors, directed corner sequences and a randomized
// run against a behavioural model of the round-robin arbiter.
module tb_bus_arbiter_rr;

    localparam int T = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;          // active-high intent; pins are driven inverted
    logic [3:0] req_n;
    logic [3:0] grnt_n;
    logic       bus_as_;
    logic       bus_rdy_;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [1:0] err_master;

    int n_pass;
    int n_total;

    assign req_n = ~req;

    bus_arbiter_rr #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req_    (req_n[0]),
        .m1_req_    (req_n[1]),
        .m2_req_    (req_n[2]),
        .m3_req_    (req_n[3]),
        .m0_grnt_   (grnt_n[0]),
        .m1_grnt_   (grnt_n[1]),
        .m2_grnt_   (grnt_n[2]),
        .m3_grnt_   (grnt_n[3]),
        .bus_as_    (bus_as_),
        .bus_rdy_   (bus_rdy_),
        .owner      (owner),
        .busy       (busy),
        .timeout    (timeout),
        .err_master (err_master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int mo;     // current owner, -1 when nobody holds the bus
    int ml;     // last granted master
    int mc;     // stalled edges seen for the current owner
    int me;     // last reclaimed master
    int mown;   // value the owner output should show
    bit mt;     // timeout pulse is visible this cycle

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (from + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] gv(input int i);
        logic [3:0] g;
        g = 4'hF;
        g[i] = 1'b0;
        return g;
    endfunction

    task automatic model_reset();
        mo = -1; ml = 3; mc = 0; me = 0; mown = 0; mt = 0;
    endtask

    task automatic model_step();
        int w;
        bit st;
        st = (bus_as_ == 1'b0) && (bus_rdy_ == 1'b1);
        if (mt) begin
            mt = 0;
        end else if (mo < 0) begin
            w = pick(req, ml);
            if (w >= 0) begin
                mo = w; ml = w; mown = w; mc = 0;
            end
        end else if (!req[mo]) begin
            w = pick(req, ml);
            mc = 0;
            mo = w;
            if (w >= 0) begin
                ml = w; mown = w;
            end
        end else if (st) begin
            if (mc == T - 1) begin
                me = mo; ml = mo; mo = -1; mt = 1; mc = 0;
            end else begin
                mc++;
            end
        end else begin
            mc = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_grnt"},    32'(grnt_n),     32'(mo < 0 ? 4'hF : gv(mo)));
        check({tag, "_busy"},    32'(busy),       32'(mo >= 0));
        check({tag, "_timeout"}, 32'(timeout),    32'(mt));
        check({tag, "_err"},     32'(err_master), 32'(me));
        if (mo >= 0) check({tag, "_owner"}, 32'(owner), 32'(mown));
    endtask

    // Called just after a clock edge; releases reset before the next one.
    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        bus_as_ = 1'b1;
        bus_rdy_ = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grnt_n;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[12];

    initial begin
        n_pass = 0;
        n_total = 0;

        // {requesting masters, expected grnt_, busy, owner}; starts with last=3
        vecs[0]  = '{4'b0000, 4'b1111, 1'b0, 2'd0};
        vecs[1]  = '{4'b1001, 4'b1110, 1'b1, 2'd0};
        vecs[2]  = '{4'b1001, 4'b1110, 1'b1, 2'd0};
        vecs[3]  = '{4'b1000, 4'b0111, 1'b1, 2'd3};
        vecs[4]  = '{4'b0110, 4'b1101, 1'b1, 2'd1};
        vecs[5]  = '{4'b0100, 4'b1011, 1'b1, 2'd2};
        vecs[6]  = '{4'b0000, 4'b1111, 1'b0, 2'd0};
        vecs[7]  = '{4'b0000, 4'b1111, 1'b0, 2'd0};
        vecs[8]  = '{4'b0010, 4'b1101, 1'b1, 2'd1};
        vecs[9]  = '{4'b0000, 4'b1111, 1'b0, 2'd0};
        vecs[10] = '{4'b1111, 4'b1011, 1'b1, 2'd2};
        vecs[11] = '{4'b1011, 4'b0111, 1'b1, 2'd3};

        // Power-on reset values.
        reset = 1'b1;
        req = 4'b0000;
        bus_as_ = 1'b1;
        bus_rdy_ = 1'b1;
        model_reset();
        #1;
        check("rst_grnt",    32'(grnt_n), 32'hF);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_owner",   32'(owner), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err",     32'(err_master), 32'd0);
        #2;
        reset = 1'b0;

        // Table vectors: one clock per record.
        for (int i = 0; i < 12; i++) begin
            req = vecs[i].req;
            tick();
            check($sformatf("vec%0d_grnt", i), 32'(grnt_n), 32'(vecs[i].grnt_n));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
            if (vecs[i].busy) check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
        end

        // Asynchronous reset mid-run with m2 granted.
        do_reset();
        req = 4'b0100;
        check("areset_latency_pre", 32'(grnt_n), 32'hF);
        tick();
        check("areset_m2_grant", 32'(grnt_n), 32'(gv(2)));
        #2;
        reset = 1'b1;
        #1;
        check("areset_grnt",  32'(grnt_n), 32'hF);
        check("areset_busy",  32'(busy), 32'd0);
        check("areset_owner", 32'(owner), 32'd0);
        #2;
        reset = 1'b0;
        model_reset();
        req = 4'b1001;
        check("post_reset_pre", 32'(grnt_n), 32'hF);
        tick();
        check("post_reset_m0", 32'(grnt_n), 32'(gv(0)));

        // Round robin with all four requesting: 0,1,2,3,0,1 back to back.
        do_reset();
        req = 4'b1111;
        tick();
        check("rr_first", 32'(grnt_n), 32'(gv(0)));
        for (int k = 0; k < 5; k++) begin
            int cur;
            int nxt;
            cur = k % 4;
            nxt = (k + 1) % 4;
            tick();
            tick();
            check($sformatf("rr_hold%0d", k), 32'(grnt_n), 32'(gv(cur)));
            req = 4'b1111 & ~(4'b0001 << cur);
            tick();
            check($sformatf("rr_handoff%0d", k), 32'(grnt_n), 32'(gv(nxt)));
            check($sformatf("rr_busy%0d", k), 32'(busy), 32'd1);
            req = 4'b1111;
        end

        // No preemption: m1 holds while m0 and m2 wait.
        do_reset();
        req = 4'b0010;
        tick();
        check("hold_m1", 32'(grnt_n), 32'(gv(1)));
        req = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold_keep%0d", i), 32'(grnt_n), 32'(gv(1)));
        end
        req = 4'b0101;
        tick();
        check("hold_next_m2", 32'(grnt_n), 32'(gv(2)));
        check("hold_next_owner", 32'(owner), 32'd2);

        // Watchdog reclaim of m3 on the 8th stalled edge.
        do_reset();
        req = 4'b1000;
        tick();
        check("wd_m3", 32'(grnt_n), 32'(gv(3)));
        req = 4'b1001;
        bus_as_ = 1'b0;
        for (int i = 1; i < T; i++) begin
            tick();
            check($sformatf("wd_stall%0d", i), 32'(grnt_n), 32'(gv(3)));
            check($sformatf("wd_nopulse%0d", i), 32'(timeout), 32'd0);
        end
        tick();
        check("wd_fire_grnt", 32'(grnt_n), 32'hF);
        check("wd_fire_pulse", 32'(timeout), 32'd1);
        check("wd_fire_err", 32'(err_master), 32'd3);
        check("wd_fire_busy", 32'(busy), 32'd0);
        bus_as_ = 1'b1;
        tick();
        check("wd_pulse_end", 32'(timeout), 32'd0);
        check("wd_idle_grnt", 32'(grnt_n), 32'hF);
        tick();
        check("wd_next_m0", 32'(grnt_n), 32'(gv(0)));
        check("wd_err_hold", 32'(err_master), 32'd3);

        // Watchdog cleared by a ready pulse on stalled cycle 6.
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        bus_as_ = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            bus_rdy_ = (i == 6) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("wdc_nopulse%0d", i), 32'(timeout), 32'd0);
            check($sformatf("wdc_grnt%0d", i), 32'(grnt_n), 32'(gv(3)));
        end
        bus_rdy_ = 1'b1;
        tick();
        check("wdc_fire", 32'(timeout), 32'd1);
        check("wdc_err", 32'(err_master), 32'd3);

        // Release on the very edge the watchdog would fire: handoff wins.
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        bus_as_ = 1'b0;
        for (int i = 1; i < T; i++) tick();
        req = 4'b0001;
        tick();
        check("race_handoff", 32'(grnt_n), 32'(gv(0)));
        check("race_nopulse", 32'(timeout), 32'd0);
        check("race_busy", 32'(busy), 32'd1);
        check("race_err", 32'(err_master), 32'd0);
        tick();
        check("race_nopulse2", 32'(timeout), 32'd0);

        // Lone offender is re-granted once the timeout cycle is over.
        do_reset();
        req = 4'b1000;
        tick();
        bus_as_ = 1'b0;
        for (int i = 1; i <= T; i++) tick();
        check("lone_fire", 32'(timeout), 32'd1);
        bus_as_ = 1'b1;
        tick();
        check("lone_idle", 32'(grnt_n), 32'hF);
        check("lone_pulse_end", 32'(timeout), 32'd0);
        tick();
        check("lone_regrant", 32'(grnt_n), 32'(gv(3)));
        check("lone_owner", 32'(owner), 32'd3);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            end
            bus_as_  = ($urandom_range(5) == 0);
            bus_rdy_ = ($urandom_range(9) != 0);
            tick();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
